linear_layer: RTL and testbench
===============================

// Module: linear_layer
// PURPOSE
//  Fully-connected N-in/N-out layer of the NETWORK1 datapath: out[i] = sum_j W[i][j]*in[j].
//  Weights are a compile-time constant matrix (no weight memory, no bias, no activation).
//  Signed fixed-point data; one registered output stage.
//  Sits between input/activation stages; one neuron sub-instance per output row.
// PARAMETERS
//  WIDTH               16   bit width of every input, weight and output (signed two's complement)
//  N                   4    number of inputs = number of outputs (square matrix)
//  FRAC                8    fractional bits of weights; product sum is arithmetically shifted right by FRAC
//  WEIGHTS_MATRIX_FLAT '0   signed [WIDTH*N*N-1:0], row-major; W[i][j] = FLAT[(N*N-(i*N+j))*WIDTH-1 -: WIDTH]
//                           (row 0 col 0 occupies the MSBs)
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               synchronous, active-high reset
//  in_valid   in   1               in[] holds a valid vector this cycle
//  in         in   [0:N-1][WIDTH]  signed input vector, unpacked array
//  out_valid  out  1               out[] holds result of the vector accepted on previous cycle
//  out        out  [0:N-1][WIDTH]  signed output vector, unpacked array
// BEHAVIOUR
//  - Reset: on posedge clk with rst=1, out[*]=0 and out_valid=0; in_valid ignored that cycle.
//  - Latency 1: vector sampled at edge k with in_valid=1 -> out/out_valid=1 visible after edge k.
//  - out_valid follows in_valid by exactly one cycle; no backpressure, one vector per clock.
//  - in_valid=0: out[] holds last value, out_valid=0.
//  - Arithmetic per row i: products WIDTH x WIDTH signed -> 2*WIDTH bits; sum in accumulator of
//    2*WIDTH+$clog2(N) bits (no intermediate overflow possible).
//  - Scaling: acc >>> FRAC (arithmetic, truncation toward -inf, no rounding).
//  - Saturation: scaled value clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1] before registering.
//  - Multiply/accumulate is combinational within the cycle; only the output is registered.
//  - No X propagation from unused state; all regs reset-defined.
// STRUCTURE
//  - Shared package: none required.
//    Weight-slice index function (row/col -> bit offset) may live in the package if reused by other layers.
//  - Sub-module linear_neuron #(WIDTH,N,FRAC,WEIGHTS_FLAT[WIDTH*N-1:0]):
//    combinational dot product + shift + saturate.
//  - Top generates gen_neuron[i].neuron_i, i=0..N-1.
//    Each gets row slice FLAT[(N-i)*WIDTH*N-1 -: WIDTH*N] (row i, col 0 in MSBs).
//  - Top owns clk/rst output register and valid flop.
// TESTING
//  1 Reset: hold rst 2 cycles with in_valid=1 -> out={0,0,0,0}, out_valid=0 throughout.
//  2 Directed vector, rows {3000,7808,-2560,-77} {308,-788,-250,-779} {-3072,7808,-2560,-747}
//    {-172,6608,-2580,-457}, in={-200,35,77,-256}, in_valid=1
//    -> next cycle out={-1970,355,3444,718}, out_valid=1.
//  3 Weight slicing: one-hot matrix W[i][j]=256 iff j==(i+1)%N, in={1,2,3,4}
//    -> out={2,3,4,1} (checks row/column order).
//  4 Saturation: all W=32767, in all 32767 -> out all 32767;
//    in all -32768 -> out all -32768 (no wrap).
//  5 Streaming: back-to-back vectors on consecutive cycles -> each result one cycle later.
//    Drop in_valid one cycle -> out_valid low that cycle, out holds value.
//  6 Reset mid-stream: assert rst while out_valid=1 -> next edge out=0, out_valid=0.
//    First valid after rst release is handled normally.

Source files
------------

// File: rtl/linear_layer_pkg.sv
// ============================================================================
// Module   : linear_layer_pkg
// Purpose  : Shared helpers for the fixed-weight linear layers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package linear_layer_pkg;

    // MSB position of element idx in a flat vector of n_elem fields of width bits,
    // with element 0 occupying the most significant field.
    function automatic int slice_msb(input int idx, input int n_elem, input int width);
        return (n_elem - idx) * width - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/linear_neuron.sv
// ============================================================================
// Module   : linear_neuron
// Purpose  : Combinational dot product of one weight row, scaled by FRAC, saturated.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module linear_neuron
    import linear_layer_pkg::*;
#(
    parameter int                   WIDTH        = 16,
    parameter int                   N            = 4,
    parameter int                   FRAC         = 8,
    parameter logic [WIDTH*N-1:0]   WEIGHTS_FLAT = '0
) (
    input  logic signed [WIDTH-1:0] in [0:N-1],
    output logic signed [WIDTH-1:0] out
);

    localparam int ACC_W = 2 * WIDTH + $clog2(N);

    localparam logic signed [ACC_W-1:0] c_max = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_min = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0]   w_weight;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_acc;
    logic signed [ACC_W-1:0]   w_scaled;

    // Accumulator carries $clog2(N) guard bits so the full sum never wraps.
    always_comb begin
        w_weight = '0;
        w_prod   = '0;
        w_acc    = '0;
        for (int j = 0; j < N; j++) begin
            w_weight = WEIGHTS_FLAT[slice_msb(j, N, WIDTH) -: WIDTH];
            w_prod   = (2*WIDTH)'(w_weight) * (2*WIDTH)'(in[j]);
            w_acc    = w_acc + ACC_W'(w_prod);
        end
    end

    assign w_scaled = w_acc >>> FRAC;

    always_comb begin
        out = w_scaled[WIDTH-1:0];
        if (w_scaled > c_max) begin
            out = c_max[WIDTH-1:0];
        end else if (w_scaled < c_min) begin
            out = c_min[WIDTH-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/linear_layer.sv
// ============================================================================
// Module   : linear_layer
// Purpose  : N-in/N-out fixed-weight fully-connected layer with one output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module linear_layer
    import linear_layer_pkg::*;
#(
    parameter int                     WIDTH               = 16,
    parameter int                     N                   = 4,
    parameter int                     FRAC                = 8,
    parameter logic [WIDTH*N*N-1:0]   WEIGHTS_MATRIX_FLAT = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in  [0:N-1],
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out [0:N-1]
);

    logic signed [WIDTH-1:0] row_result [0:N-1];
    logic signed [WIDTH-1:0] out_d      [0:N-1];
    logic signed [WIDTH-1:0] out_q      [0:N-1];
    logic                    out_valid_d;
    logic                    out_valid_q;

    // Row i of the matrix sits in field i of the flat vector, row 0 in the MSBs.
    for (genvar i = 0; i < N; i++) begin : gen_neuron
        linear_neuron #(
            .WIDTH        (WIDTH),
            .N            (N),
            .FRAC         (FRAC),
            .WEIGHTS_FLAT (WEIGHTS_MATRIX_FLAT[slice_msb(i, N, WIDTH*N) -: WIDTH*N])
        ) neuron_i (
            .in  (in),
            .out (row_result[i])
        );
    end

    always_comb begin
        out_valid_d = in_valid;
        for (int i = 0; i < N; i++) begin
            out_d[i] = in_valid ? row_result[i] : out_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            for (int i = 0; i < N; i++) begin
                out_q[i] <= out_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

`default_nettype wire

// File: tb/tb_linear_layer.sv
// ============================================================================
// Module   : tb_linear_layer
// Purpose  : Directed, table-driven bench for linear_layer over three weight sets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_linear_layer;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int FRAC  = 8;

    // Hand-picked matrix, one-hot rotate-left matrix (256 = 1.0), all-max matrix.
    localparam logic [WIDTH*N*N-1:0] c_w_a = {
         16'sd3000,  16'sd7808, -16'sd2560,  -16'sd77,
         16'sd308,  -16'sd788,  -16'sd250,  -16'sd779,
        -16'sd3072,  16'sd7808, -16'sd2560, -16'sd747,
        -16'sd172,   16'sd6608, -16'sd2580, -16'sd457
    };
    localparam logic [WIDTH*N*N-1:0] c_w_b = {
        16'sd0,   16'sd256, 16'sd0,   16'sd0,
        16'sd0,   16'sd0,   16'sd256, 16'sd0,
        16'sd0,   16'sd0,   16'sd0,   16'sd256,
        16'sd256, 16'sd0,   16'sd0,   16'sd0
    };
    localparam logic [WIDTH*N*N-1:0] c_w_c = {16{16'sd32767}};

    typedef logic signed [0:N-1][WIDTH-1:0] pvec_t;

    typedef struct packed {
        logic [1:0] sel;
        pvec_t      in_v;
        pvec_t      exp_v;
    } vec_rec_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic signed [WIDTH-1:0] in_arr [0:N-1];
    logic                    out_valid_a, out_valid_b, out_valid_c;
    logic signed [WIDTH-1:0] out_a [0:N-1];
    logic signed [WIDTH-1:0] out_b [0:N-1];
    logic signed [WIDTH-1:0] out_c [0:N-1];

    int n_vec  = 0;
    int n_fail = 0;

    vec_rec_t tbl [$];

    always #5 clk = ~clk;

    linear_layer #(.WIDTH(WIDTH), .N(N), .FRAC(FRAC), .WEIGHTS_MATRIX_FLAT(c_w_a)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_arr),
        .out_valid(out_valid_a), .out(out_a)
    );
    linear_layer #(.WIDTH(WIDTH), .N(N), .FRAC(FRAC), .WEIGHTS_MATRIX_FLAT(c_w_b)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_arr),
        .out_valid(out_valid_b), .out(out_b)
    );
    linear_layer #(.WIDTH(WIDTH), .N(N), .FRAC(FRAC), .WEIGHTS_MATRIX_FLAT(c_w_c)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_arr),
        .out_valid(out_valid_c), .out(out_c)
    );

    task automatic add(input logic [1:0] sel, input pvec_t in_v, input pvec_t exp_v);
        vec_rec_t r;
        r.sel   = sel;
        r.in_v  = in_v;
        r.exp_v = exp_v;
        tbl.push_back(r);
    endtask

    task automatic drive(input logic v, input pvec_t in_v);
        in_valid = v;
        for (int i = 0; i < N; i++) in_arr[i] = in_v[i];
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] sel,
                         input pvec_t exp_v, input logic exp_valid);
        pvec_t got;
        logic  got_valid;
        for (int i = 0; i < N; i++) begin
            case (sel)
                2'd0:    got[i] = out_a[i];
                2'd1:    got[i] = out_b[i];
                default: got[i] = out_c[i];
            endcase
        end
        case (sel)
            2'd0:    got_valid = out_valid_a;
            2'd1:    got_valid = out_valid_b;
            default: got_valid = out_valid_c;
        endcase
        n_vec++;
        if (got !== exp_v || got_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL %s: got out={%0d,%0d,%0d,%0d} valid=%b, want out={%0d,%0d,%0d,%0d} valid=%b",
                     name, got[0], got[1], got[2], got[3], got_valid,
                     exp_v[0], exp_v[1], exp_v[2], exp_v[3], exp_valid);
        end
    endtask

    initial begin
        pvec_t zero_v;
        pvec_t res2;
        zero_v = '0;
        res2   = {-16'sd1970, 16'sd355, 16'sd3444, 16'sd718};

        add(2'd0, {-16'sd200, 16'sd35, 16'sd77, -16'sd256}, res2);
        add(2'd0, {16'sd256, 16'sd0, 16'sd0, 16'sd0},       {16'sd3000, 16'sd308, -16'sd3072, -16'sd172});
        add(2'd0, {16'sd0, 16'sd0, 16'sd0, -16'sd1},        {16'sd0, 16'sd3, 16'sd2, 16'sd1});
        add(2'd0, {16'sd0, 16'sd0, 16'sd0, 16'sd1},         {-16'sd1, -16'sd4, -16'sd3, -16'sd2});
        add(2'd0, {4{16'sd32767}},                          {16'sd32767, -16'sd32768, 16'sd32767, 16'sd32767});
        add(2'd1, {16'sd1, 16'sd2, 16'sd3, 16'sd4},         {16'sd2, 16'sd3, 16'sd4, 16'sd1});
        add(2'd1, {-16'sd1, -16'sd2, -16'sd3, -16'sd4},     {-16'sd2, -16'sd3, -16'sd4, -16'sd1});
        add(2'd1, {16'sd100, -16'sd200, 16'sd300, -16'sd32768}, {-16'sd200, 16'sd300, -16'sd32768, 16'sd100});
        add(2'd2, {4{16'sd32767}},                          {4{16'sd32767}});
        add(2'd2, {4{-16'sd32768}},                         {4{-16'sd32768}});
        add(2'd2, {16'sd1, 16'sd0, 16'sd0, 16'sd0},         {4{16'sd127}});
        add(2'd2, {-16'sd1, 16'sd0, 16'sd0, 16'sd0},        {4{-16'sd128}});
        add(2'd2, zero_v,                                   zero_v);

        // Reset held two cycles with in_valid high must keep outputs cleared.
        rst = 1'b1;
        drive(1'b1, {16'sd5, 16'sd6, 16'sd7, 16'sd8});
        tick();
        check("reset_cycle1_a", 2'd0, zero_v, 1'b0);
        check("reset_cycle1_c", 2'd2, zero_v, 1'b0);
        tick();
        check("reset_cycle2_a", 2'd0, zero_v, 1'b0);

        rst = 1'b0;
        drive(1'b0, {16'sd5, 16'sd6, 16'sd7, 16'sd8});
        tick();
        check("idle_after_reset", 2'd0, zero_v, 1'b0);

        // Table applied back-to-back: each result appears one cycle after its vector.
        foreach (tbl[k]) begin
            drive(1'b1, tbl[k].in_v);
            tick();
            check($sformatf("vec%0d", k), tbl[k].sel, tbl[k].exp_v, 1'b1);
        end

        // Drop in_valid: out_valid falls, output holds previous result.
        drive(1'b1, {-16'sd200, 16'sd35, 16'sd77, -16'sd256});
        tick();
        check("stream_before_gap", 2'd0, res2, 1'b1);
        drive(1'b0, {16'sd256, 16'sd256, 16'sd256, 16'sd256});
        tick();
        check("gap_hold", 2'd0, res2, 1'b0);
        tick();
        check("gap_hold2", 2'd0, res2, 1'b0);
        drive(1'b1, {16'sd1, 16'sd2, 16'sd3, 16'sd4});
        tick();
        check("after_gap_b", 2'd1, {16'sd2, 16'sd3, 16'sd4, 16'sd1}, 1'b1);

        // Reset while out_valid is high, then first vector after release.
        rst = 1'b1;
        drive(1'b1, {16'sd1, 16'sd2, 16'sd3, 16'sd4});
        tick();
        check("midreset_a", 2'd0, zero_v, 1'b0);
        check("midreset_b", 2'd1, zero_v, 1'b0);
        rst = 1'b0;
        drive(1'b1, {-16'sd200, 16'sd35, 16'sd77, -16'sd256});
        tick();
        check("post_reset_vec", 2'd0, res2, 1'b1);
        drive(1'b0, zero_v);
        tick();
        check("post_reset_idle", 2'd0, res2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
